// File: rtl/spec_pulse_accumulator.sv
// spec_pulse_accumulator
// Detects a rising threshold crossing on an unsigned ADC sample stream, sums
// a fixed window of ACC_LEN valid samples and strobes SPEC_Acc_Done for one
// cycle with the registered window sum. Crossings that arrive while a window
// or its dead-time is in progress are counted as pile-ups.
//
// Build option: define SPEC_BASELINE_SUB_EN to sum max(adc_data-thr,0)
// (area above threshold) instead of the raw sample. Ports are identical in
// both builds.
module spec_pulse_accumulator #(
  parameter int ADC_W   = 14,
  parameter int ACC_LEN = 16,
  parameter int SUM_W   = 19,
  parameter int HOLDOFF = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Capture_En,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  input  logic [ADC_W-1:0] thr,
  output logic [SUM_W-1:0] spec_sum,
  output logic             SPEC_Acc_Done,
  output logic [15:0]      pileup_cnt,
  output logic             busy
);

  // Window counter must reach ACC_LEN; hold counter must hold HOLDOFF-1.
  localparam int CNT_W  = $clog2(ACC_LEN + 1);
  localparam int HOLD_W = ($clog2(HOLDOFF) > 0) ? $clog2(HOLDOFF) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [SUM_W-1:0]  acc;
  logic [CNT_W-1:0]  win_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              above_q;

  logic              above_now;
  logic              crossing;
  logic              win_last;
  logic [SUM_W-1:0]  term;

  // Saturating increment for the pile-up counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] c);
    if (c == 16'hFFFF) begin
      return c;
    end
    return c + 16'd1;
  endfunction

`ifdef SPEC_BASELINE_SUB_EN
  // Area above threshold: negative excursions clip to zero.
  function automatic logic [SUM_W-1:0] sample_term(input logic [ADC_W-1:0] d,
                                                   input logic [ADC_W-1:0] t);
    if (d >= t) begin
      return SUM_W'(d - t);
    end
    return '0;
  endfunction

  assign term = sample_term(adc_data, thr);
`else
  // Raw sample, zero-extended to the sum width.
  function automatic logic [SUM_W-1:0] sample_term(input logic [ADC_W-1:0] d);
    return SUM_W'(d);
  endfunction

  assign term = sample_term(adc_data);
`endif

  assign above_now = (adc_data >= thr);
  assign crossing  = adc_valid & above_now & ~above_q;
  // The accepted sample that brings the count to ACC_LEN closes the window.
  assign win_last  = (win_cnt == CNT_W'(ACC_LEN - 1));

  // Remember whether the last valid sample was at/above threshold; reset to 1
  // so a stream that starts above threshold cannot trigger.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      above_q <= 1'b1;
    end else if (adc_valid) begin
      above_q <= above_now;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; Capture_En low forces IDLE from any state.
  always_comb begin
    state_d = state_q;
    if (!Capture_En) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (crossing) state_d = S_ACC;
        S_ACC:   if (adc_valid && win_last) state_d = S_DONE;
        S_DONE:  state_d = S_HOLD;
        S_HOLD:  if (hold_cnt == '0) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: Done is exactly the single DONE-state cycle.
  always_comb begin
    busy          = (state_q != S_IDLE);
    SPEC_Acc_Done = (state_q == S_DONE);
  end

  // Window accumulator and sample counter; invalid cycles stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      win_cnt <= '0;
    end else if (!Capture_En) begin
      acc     <= '0;
      win_cnt <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (crossing) begin
            acc     <= term;
            win_cnt <= CNT_W'(1);
          end
        end
        S_ACC: begin
          if (adc_valid) begin
            acc     <= acc + term;
            win_cnt <= win_cnt + CNT_W'(1);
          end
        end
        default: begin
          acc     <= acc;
          win_cnt <= win_cnt;
        end
      endcase
    end
  end

  // Result register: loaded with the completed window, retained otherwise
  // (including while Capture_En is low).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spec_sum <= '0;
    end else if (Capture_En && (state_q == S_ACC) && adc_valid && win_last) begin
      spec_sum <= acc + term;
    end
  end

  // Dead-time counter loaded on DONE and run down in HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (!Capture_En) begin
      hold_cnt <= '0;
    end else if (state_q == S_DONE) begin
      hold_cnt <= HOLD_W'(HOLDOFF - 1);
    end else if ((state_q == S_HOLD) && (hold_cnt != '0)) begin
      hold_cnt <= hold_cnt - HOLD_W'(1);
    end
  end

  // Count crossings rejected while a window or its dead-time is active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pileup_cnt <= '0;
    end else if (!Capture_En) begin
      pileup_cnt <= '0;
    end else if (crossing && (state_q != S_IDLE)) begin
      pileup_cnt <= sat_inc16(pileup_cnt);
    end
  end

endmodule

// File: tb/tb_spec_pulse_accumulator.sv
// Testbench for spec_pulse_accumulator: expected window sums are queued when
// a window's stimulus is driven and checked whenever SPEC_Acc_Done fires.
module tb_spec_pulse_accumulator;

  localparam int ADC_W   = 14;
  localparam int ACC_LEN = 16;
  localparam int SUM_W   = 19;
  localparam int HOLDOFF = 8;
  localparam logic [ADC_W-1:0] THR = 14'd100;
`ifdef SPEC_BASELINE_SUB_EN
  localparam logic [SUM_W-1:0] T1_SUM = 19'd1600;
`else
  localparam logic [SUM_W-1:0] T1_SUM = 19'd3200;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             Capture_En;
  logic [ADC_W-1:0] adc_data;
  logic             adc_valid;
  logic [ADC_W-1:0] thr;
  logic [SUM_W-1:0] spec_sum;
  logic             SPEC_Acc_Done;
  logic [15:0]      pileup_cnt;
  logic             busy;

  int tests = 0;
  int fails = 0;
  int done_seen = 0;
  logic [SUM_W-1:0] exp_q[$];
  logic [SUM_W-1:0] last_sum;

  spec_pulse_accumulator #(
    .ADC_W(ADC_W), .ACC_LEN(ACC_LEN), .SUM_W(SUM_W), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Capture_En(Capture_En),
    .adc_data(adc_data), .adc_valid(adc_valid), .thr(thr),
    .spec_sum(spec_sum), .SPEC_Acc_Done(SPEC_Acc_Done),
    .pileup_cnt(pileup_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  // Contribution of one accepted sample to the window sum.
  function automatic logic [SUM_W-1:0] exp_term(input logic [ADC_W-1:0] d);
`ifdef SPEC_BASELINE_SUB_EN
    return (d >= THR) ? SUM_W'(d - THR) : '0;
`else
    return SUM_W'(d);
`endif
  endfunction

  // Scoreboard: every Done must match the oldest queued window sum.
  always @(negedge clk) begin
    logic [SUM_W-1:0] e;
    if (rst_n && SPEC_Acc_Done) begin
      done_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL done_unexpected: spec_sum=%0d, required no Done", spec_sum);
      end else begin
        e = exp_q.pop_front();
        if (spec_sum !== e) begin
          fails++;
          $display("FAIL done_sum: spec_sum=%0d, required %0d", spec_sum, e);
        end
      end
    end
  end

  task automatic cyc(input logic [ADC_W-1:0] d, input logic v);
    adc_data  = d;
    adc_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic push_win(input logic [SUM_W-1:0] s);
    exp_q.push_back(s);
    last_sum = s;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy === 1'b1 && n < 50) begin
      cyc(14'd0, 1'b0);
      n++;
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; Capture_En = 1'b1; adc_data = '0; adc_valid = 1'b0; thr = THR;
    #3;
    tests++;
    if ({spec_sum, SPEC_Acc_Done, pileup_cnt, busy} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: sum=%0d done=%b pile=%0d busy=%b, required all 0",
               spec_sum, SPEC_Acc_Done, pileup_cnt, busy);
    end
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    // First sample above threshold must not trigger.
    cyc(14'd200, 1'b1);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_no_trigger: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_basic_window();
    cyc(14'd50, 1'b1);
    push_win(exp_term(14'd200) * SUM_W'(16));
    for (int i = 0; i < 16; i++) cyc(14'd200, 1'b1);
    tests++;
    if (SPEC_Acc_Done !== 1'b1 || spec_sum !== T1_SUM) begin
      fails++;
      $display("FAIL basic_done: done=%b sum=%0d, required 1 and %0d",
               SPEC_Acc_Done, spec_sum, T1_SUM);
    end
    for (int i = 0; i < HOLDOFF; i++) cyc(14'd0, 1'b0);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_holdoff_busy: busy=%b, required 1", busy);
    end
    cyc(14'd0, 1'b0);
    tests++;
    if (busy !== 1'b0 || pileup_cnt !== 16'd0) begin
      fails++;
      $display("FAIL basic_idle: busy=%b pile=%0d, required 0 and 0", busy, pileup_cnt);
    end
  endtask

  task automatic test_valid_toggle();
    cyc(14'd50, 1'b1);
    push_win(exp_term(14'd200) * SUM_W'(16));
    cyc(14'd200, 1'b1);
    for (int i = 0; i < 15; i++) begin
      cyc(14'd3000, 1'b0);
      cyc(14'd200, 1'b1);
    end
    tests++;
    if (SPEC_Acc_Done !== 1'b1 || spec_sum !== T1_SUM) begin
      fails++;
      $display("FAIL toggle_done: done=%b sum=%0d, required 1 and %0d",
               SPEC_Acc_Done, spec_sum, T1_SUM);
    end
    wait_idle();
  endtask

  task automatic test_pileup();
    int d0;
    logic [ADC_W-1:0] win[16];
    logic [SUM_W-1:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) win[i] = 14'd200;
    win[3] = 14'd50;   // dip so window sample 5 is a fresh crossing
    for (int i = 0; i < 16; i++) s = s + exp_term(win[i]);
    d0 = done_seen;
    cyc(14'd50, 1'b1);
    push_win(s);
    for (int i = 0; i < 16; i++) cyc(win[i], 1'b1);
    tests++;
    if (SPEC_Acc_Done !== 1'b1) begin
      fails++;
      $display("FAIL pileup_done: done=%b, required 1", SPEC_Acc_Done);
    end
    cyc(14'd50, 1'b1);
    cyc(14'd200, 1'b1);   // crossing during HOLDOFF
    wait_idle();
    tests++;
    if (pileup_cnt !== 16'd2) begin
      fails++;
      $display("FAIL pileup_count: pile=%0d, required 2", pileup_cnt);
    end
    tests++;
    if (done_seen - d0 !== 1) begin
      fails++;
      $display("FAIL pileup_single_done: dones=%0d, required 1", done_seen - d0);
    end
  endtask

  task automatic test_capture_drop();
    logic [SUM_W-1:0] old_sum;
    old_sum = last_sum;
    cyc(14'd50, 1'b1);
    for (int i = 0; i < 9; i++) cyc(14'd200, 1'b1);
    Capture_En = 1'b0;
    cyc(14'd200, 1'b1);
    tests++;
    if (busy !== 1'b0 || pileup_cnt !== 16'd0 || spec_sum !== old_sum || SPEC_Acc_Done !== 1'b0) begin
      fails++;
      $display("FAIL capture_drop: busy=%b pile=%0d sum=%0d done=%b, required 0 0 %0d 0",
               busy, pileup_cnt, spec_sum, SPEC_Acc_Done, old_sum);
    end
    cyc(14'd50, 1'b1);
    cyc(14'd50, 1'b1);
    // Crossing on the same cycle Capture_En rises is accepted.
    Capture_En = 1'b1;
    push_win(exp_term(14'd200) * SUM_W'(16));
    cyc(14'd200, 1'b1);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL capture_rise_trigger: busy=%b, required 1", busy);
    end
    for (int i = 0; i < 15; i++) cyc(14'd200, 1'b1);
    tests++;
    if (SPEC_Acc_Done !== 1'b1 || spec_sum !== T1_SUM) begin
      fails++;
      $display("FAIL capture_rise_done: done=%b sum=%0d, required 1 and %0d",
               SPEC_Acc_Done, spec_sum, T1_SUM);
    end
    wait_idle();
  endtask

  task automatic test_async_reset();
    cyc(14'd50, 1'b1);
    for (int i = 0; i < 5; i++) cyc(14'd200, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({spec_sum, SPEC_Acc_Done, pileup_cnt, busy} !== '0) begin
      fails++;
      $display("FAIL async_reset: sum=%0d done=%b pile=%0d busy=%b, required all 0",
               spec_sum, SPEC_Acc_Done, pileup_cnt, busy);
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(14'd200, 1'b1);
      tests++;
      if (busy !== 1'b0) begin
        fails++;
        $display("FAIL async_no_retrigger: busy=%b at sample %0d, required 0", busy, i);
      end
    end
    cyc(14'd50, 1'b1);
    push_win(exp_term(14'd200) * SUM_W'(16));
    cyc(14'd200, 1'b1);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL async_rearm: busy=%b, required 1", busy);
    end
    for (int i = 0; i < 15; i++) cyc(14'd200, 1'b1);
    tests++;
    if (SPEC_Acc_Done !== 1'b1 || spec_sum !== T1_SUM) begin
      fails++;
      $display("FAIL async_done: done=%b sum=%0d, required 1 and %0d",
               SPEC_Acc_Done, spec_sum, T1_SUM);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_valid_toggle();
    test_pileup();
    test_capture_drop();
    test_async_reset();
    cyc(14'd0, 1'b0);
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_done: %0d windows never completed, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
